// File: rtl/display_scan_driver_if.sv
// Signal bundle between the seven-segment scan driver and the logic that feeds it.
// The slave side is the driver. The master side supplies the scan clock, the digits and the enable.
interface display_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    scan_clk;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    enable;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output scan_clk, value, dp_mask, enable,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  scan_clk, value, dp_mask, enable,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/display_scan_driver.sv
// Drives a time-multiplexed common-anode seven-segment display (active-low anodes, segments and dp).
// Each rising edge of the synchronised scan clock advances one digit, and the value is snapshotted once per frame.
module display_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                  clk_in,
  input logic                  reset,
  display_scan_driver_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                    s1, s2, s_prev;
  logic                    step, last;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    wrap_p1;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    blank, dark;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q_out;
  logic                    frame_q;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

  // Bit i is set when digit i and every digit above it are zero with no decimal point lit.
  // A lit dp therefore keeps the zeros below it visible.
  function automatic logic [NUM_DIGITS-1:0] leading_zero(
    input logic [4*NUM_DIGITS-1:0] v,
    input logic [NUM_DIGITS-1:0]   d
  );
    logic                  run;
    logic [NUM_DIGITS-1:0] r;
    run = 1'b1;
    r   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run  = run & (v[4*i +: 4] == 4'h0) & ~d[i];
      r[i] = run;
    end
    return r;
  endfunction

  assign step      = s2 & ~s_prev;
  assign last      = (idx == LAST_IDX);
  assign nib       = value_q[{idx, 2'b00} +: 4];
  assign lead_zero = leading_zero(value_q, dp_q);
  assign blank     = BLANK_LEADING && (idx != '0) && lead_zero[idx];
  assign dark      = ~bus.enable | blank;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s_prev   <= 1'b0;
      idx      <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      wrap_p1  <= 1'b0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q_out <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      // Synchroniser and edge detect
      s1      <= bus.scan_clk;
      s2      <= s1;
      s_prev  <= s2;
      // Digit advance and frame snapshot
      wrap_p1 <= step & last;
      if (step) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          value_q <= bus.value;
          dp_q    <= bus.dp_mask;
        end
      end
      // Registered display outputs
      frame_q <= wrap_p1;
      if (dark) begin
        an_q     <= '1;
        seg_q    <= 7'h7F;
        dp_q_out <= 1'b1;
      end else begin
        an_q     <= ~(NUM_DIGITS'(1) << idx);
        seg_q    <= decode(nib);
        dp_q_out <= ~dp_q[idx];
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q_out;
  assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: one instance without and one with leading-zero blanking.
// Stimulus queues each expected output change with its cycle, and a negedge monitor pops and compares.
module tb_display_scan_driver;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } exp_t;

  localparam out_t DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk_in = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        enable;

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  display_scan_driver_if #(.NUM_DIGITS(N)) b0 ();
  display_scan_driver_if #(.NUM_DIGITS(N)) b1 ();

  assign b0.scan_clk = scan_clk;
  assign b0.value    = value;
  assign b0.dp_mask  = dp_mask;
  assign b0.enable   = enable;
  assign b1.scan_clk = scan_clk;
  assign b1.value    = value;
  assign b1.dp_mask  = dp_mask;
  assign b1.enable   = enable;

  display_scan_driver #(.NUM_DIGITS(N), .BLANK_LEADING(1'b0)) u0 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (b0.slave)
  );

  display_scan_driver #(.NUM_DIGITS(N), .BLANK_LEADING(1'b1)) u1 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (b1.slave)
  );

  // Expected-side state: what each instance should currently show
  int          idx_m;
  logic        en_m;
  logic [31:0] cur_val, pend_val;
  logic [7:0]  cur_dp, pend_dp;
  logic [7:0]  cur_lit [2];
  logic [7:0]  pend_lit [2];
  out_t        last_exp [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  int   checks = 0;
  int   errors = 0;
  int   rst_chk_cyc = -1;
  int   fin_chk_cyc = -1;
  logic mon_on = 1'b0;
  out_t last_obs0 = DARK;
  out_t last_obs1 = DARK;

  function automatic out_t disp(input int inst, input int d);
    out_t       o;
    logic [3:0] n;
    o = DARK;
    if (en_m && cur_lit[inst][d]) begin
      n     = cur_val[4*d +: 4];
      o.an  = ~(8'h01 << d);
      o.seg = SEG[n];
      o.dp  = ~cur_dp[d];
    end
    return o;
  endfunction

  task automatic push(input int inst, input int c, input out_t o);
    exp_t e;
    if (o !== last_exp[inst]) begin
      e.cyc = c;
      e.o   = o;
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
      last_exp[inst] = o;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic cmp(input string name, input out_t act, input out_t exp_o,
                     input int act_c, input int exp_c);
    checks++;
    if (act !== exp_o || act_c != exp_c) begin
      errors++;
      $display("FAIL %s: at cycle %0d got an=%h seg=%h dp=%b fs=%b, expected at cycle %0d an=%h seg=%h dp=%b fs=%b",
               name, act_c, act.an, act.seg, act.dp, act.fs,
               exp_c, exp_o.an, exp_o.seg, exp_o.dp, exp_o.fs);
    end
  endtask

  // A scan clock edge raised just after edge c is sampled at c+1, so the new digit shows at c+4
  task automatic do_step();
    int   c;
    out_t o;
    logic wrap;
    scan_clk = 1'b1;
    c        = cyc;
    idx_m    = (idx_m == N - 1) ? 0 : idx_m + 1;
    wrap     = (idx_m == 0);
    if (wrap) begin
      cur_val = pend_val;
      cur_dp  = pend_dp;
      cur_lit = pend_lit;
    end
    for (int i = 0; i < 2; i++) begin
      o    = disp(i, idx_m);
      o.fs = wrap;
      push(i, c + 4, o);
      if (wrap) begin
        o.fs = 1'b0;
        push(i, c + 5, o);
      end
    end
    wait_cycles(10);
    scan_clk = 1'b0;
    wait_cycles(10);
  endtask

  task automatic frame();
    repeat (N) do_step();
  endtask

  task automatic set_value(input logic [31:0] v, input logic [7:0] m,
                           input logic [7:0] lit0, input logic [7:0] lit1);
    value       = v;
    dp_mask     = m;
    pend_val    = v;
    pend_dp     = m;
    pend_lit[0] = lit0;
    pend_lit[1] = lit1;
  endtask

  task automatic set_enable(input logic e);
    int c;
    enable = e;
    c      = cyc;
    en_m   = e;
    for (int i = 0; i < 2; i++) push(i, c + 1, disp(i, idx_m));
    wait_cycles(3);
  endtask

  task automatic clear_model();
    idx_m      = 0;
    en_m       = 1'b1;
    cur_val    = '0;
    cur_dp     = '0;
    cur_lit[0] = 8'hFF;
    cur_lit[1] = 8'h01;
  endtask

  // Reset lands on the same edge (c+3) at which the step would have advanced idx
  task automatic reset_on_step();
    int c;
    scan_clk = 1'b1;
    c        = cyc;
    clear_model();
    for (int i = 0; i < 2; i++) begin
      push(i, c + 3, DARK);
      push(i, c + 5, disp(i, 0));
    end
    rst_chk_cyc = c + 3;
    wait_cycles(2);
    reset    = 1'b1;
    scan_clk = 1'b0;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  always @(negedge clk_in) begin
    out_t o0, o1;
    exp_t e;
    if (mon_on) begin
      o0 = {b0.an, b0.seg, b0.dp, b0.frame_start};
      o1 = {b1.an, b1.seg, b1.dp, b1.frame_start};
      if (cyc == rst_chk_cyc) begin
        cmp("reset_dark_bl0", o0, DARK, cyc, rst_chk_cyc);
        cmp("reset_dark_bl1", o1, DARK, cyc, rst_chk_cyc);
      end
      if (o0 !== last_obs0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change_bl0: at cycle %0d got an=%h seg=%h dp=%b fs=%b, expected no change",
                   cyc, o0.an, o0.seg, o0.dp, o0.fs);
        end else begin
          e = q0.pop_front();
          cmp("scan_bl0", o0, e.o, cyc, e.cyc);
        end
        last_obs0 = o0;
      end
      if (o1 !== last_obs1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change_bl1: at cycle %0d got an=%h seg=%h dp=%b fs=%b, expected no change",
                   cyc, o1.an, o1.seg, o1.dp, o1.fs);
        end else begin
          e = q1.pop_front();
          cmp("scan_bl1", o1, e.o, cyc, e.cyc);
        end
        last_obs1 = o1;
      end
      if (cyc == fin_chk_cyc) begin
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
          errors++;
          $display("FAIL missing_changes: %0d/%0d expected output changes never seen, required 0/0",
                   q0.size(), q1.size());
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    scan_clk = 1'b0;
    enable   = 1'b1;
    value    = '0;
    dp_mask  = '0;
    clear_model();
    pend_val    = '0;
    pend_dp     = '0;
    pend_lit[0] = 8'hFF;
    pend_lit[1] = 8'h01;
    last_exp[0] = DARK;
    last_exp[1] = DARK;

    wait_cycles(3);
    mon_on      = 1'b1;
    rst_chk_cyc = cyc;
    reset       = 1'b0;
    for (int i = 0; i < 2; i++) push(i, cyc + 1, disp(i, 0));
    wait_cycles(20);

    set_value(32'h0000_1234, 8'h00, 8'hFF, 8'h0F);
    frame();
    set_value(32'h0000_0000, 8'h00, 8'hFF, 8'h01);
    frame();
    set_value(32'h0000_0000, 8'h04, 8'hFF, 8'h07);
    frame();
    set_value(32'h1111_1111, 8'h00, 8'hFF, 8'hFF);
    frame();

    repeat (3) do_step();
    set_value(32'h2222_2222, 8'h00, 8'hFF, 8'hFF);
    repeat (5) do_step();

    repeat (5) do_step();
    set_enable(1'b0);
    repeat (3) do_step();
    set_enable(1'b1);
    repeat (2) do_step();

    reset_on_step();
    wait_cycles(10);
    do_step();

    wait_cycles(5);
    fin_chk_cyc = cyc + 1;
    wait_cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
